// File: rtl/edge_detect_bank.sv
// Multi-channel input conditioner: per channel a synchroniser, a stability filter,
// a selectable edge detector and a sticky write-one-to-clear pending flag.
module edge_detect_bank #(
    parameter int CHANNELS      = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CHANNELS-1:0]   din,
    input  logic [2*CHANNELS-1:0] edge_sel,
    input  logic [CHANNELS-1:0]   clear,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic                  irq
);

    localparam int CW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  level_q, level_d;
    logic [CHANNELS-1:0]                  pulse_q, pulse_d;
    logic [CHANNELS-1:0]                  pending_q, pending_d;
    logic [CHANNELS-1:0]                  s;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], din};
        s         = sync_q[SYNC_STAGES-1];
        cnt_d     = cnt_q;
        level_d   = level_q;
        pulse_d   = '0;
        // A new level is accepted only once the count has run out with no break.
        for (int i = 0; i < CHANNELS; i++) begin
            if (s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(FILTER_CYCLES)) begin
                level_d[i] = s[i];
                cnt_d[i]   = '0;
                pulse_d[i] = s[i] ? edge_sel[2*i] : edge_sel[2*i+1];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        pending_d = pulse_q | (pending_q & ~clear);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            pulse_q   <= '0;
            pending_q <= '0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
        end
    end

    assign level   = level_q;
    assign pulse   = pulse_q;
    assign pending = pending_q;
    assign irq     = |pending_q;

endmodule
